// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges Ports AXI-stream byte sources into one UART TX FIFO input.
// Optional macro ARB_ID_HEADER_EN prefixes every grant with a header beat of 8'hA0 + grant_id.
module uart_tx_arbiter #(
  parameter int Width      = 8,
  parameter int Ports      = 4,
  parameter int Max_burst  = 16,
  parameter int Idle_limit = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Ports*Width-1:0]     s_axis_tdata,
  input  logic [Ports-1:0]           s_axis_tvalid,
  input  logic [Ports-1:0]           s_axis_tlast,
  output logic [Ports-1:0]           s_axis_tready,
  output logic [Width-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(Ports)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IdW   = $clog2(Ports);
  localparam int BeatW = $clog2(Max_burst + 1);
  localparam int IdleW = $clog2(Idle_limit + 1);

`ifdef ARB_ID_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

  state_t             state, state_next;
  logic [IdW-1:0]     rr_ptr, rr_ptr_next, grant_next, pick, scan_idx, grant_inc;
  logic [BeatW-1:0]   beat_cnt, beat_cnt_next;
  logic [IdleW-1:0]   idle_cnt, idle_cnt_next;
  logic [Width-1:0]   lane [Ports];
  logic               grant_valid, grant_last, release_grant;

  for (genvar g = 0; g < Ports; g++) begin : g_lane
    assign lane[g] = s_axis_tdata[g*Width +: Width];
  end

  assign grant_valid = s_axis_tvalid[grant_id];
  assign grant_last  = s_axis_tlast[grant_id];
  assign grant_inc   = (grant_id == IdW'(Ports - 1)) ? '0 : grant_id + IdW'(1);
  assign busy        = (state != IDLE);

  // Scan from the far end so the requester nearest to rr_ptr overwrites the others.
  always_comb begin
    pick     = rr_ptr;
    scan_idx = '0;
    for (int k = Ports - 1; k >= 0; k--) begin
      scan_idx = IdW'((int'(rr_ptr) + k) % Ports);
      if (s_axis_tvalid[scan_idx]) pick = scan_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      grant_id <= grant_next;
      beat_cnt <= beat_cnt_next;
      idle_cnt <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    grant_next    = grant_id;
    beat_cnt_next = beat_cnt;
    idle_cnt_next = idle_cnt;
    release_grant = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;

    case (state)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_next    = pick;
          beat_cnt_next = '0;
          idle_cnt_next = '0;
`ifdef ARB_ID_HEADER_EN
          state_next    = HDR;
`else
          state_next    = XFER;
`endif
        end
      end
`ifdef ARB_ID_HEADER_EN
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = Width'(8'hA0) + Width'(grant_id);
        idle_cnt_next = '0;
        if (m_axis_tready) state_next = XFER;
      end
`endif
      XFER: begin
        m_axis_tdata            = lane[grant_id];
        m_axis_tvalid           = grant_valid;
        s_axis_tready[grant_id] = m_axis_tready;
        if (grant_valid) begin
          idle_cnt_next = '0;
          if (m_axis_tready) begin
            beat_cnt_next = beat_cnt + BeatW'(1);
            if (grant_last || beat_cnt == BeatW'(Max_burst - 1)) release_grant = 1'b1;
          end
        end else begin
          idle_cnt_next = idle_cnt + IdleW'(1);
          if (idle_cnt == IdleW'(Idle_limit - 1)) release_grant = 1'b1;
        end
        if (release_grant) begin
          state_next  = IDLE;
          rr_ptr_next = grant_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit byte path between `Ports` AXI-stream byte sources. It sits upstream of the transmit FIFO and drives that FIFO's `s_axis_*` slave port. It grants one source at a time and holds the grant for a whole packet, bounded by a burst limit and an idle timeout. The output stream is therefore a sequence of uninterleaved per-source bursts.

## Interface

Parameters:
- `Width`, 8: byte width of every data lane.
- `Ports`, 4: number of requesters, 2..16.
- `Max_burst`, 16: maximum data beats per grant, ≥1.
- `Idle_limit`, 8: consecutive cycles with granted `tvalid` low before the grant is revoked, ≥1.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `s_axis_tdata`  in  Ports*Width: source `i` on bits `[i*Width +: Width]`.
- `s_axis_tvalid`  in  Ports: per-source valid.
- `s_axis_tlast`  in  Ports: per-source end-of-packet.
- `s_axis_tready`  out  Ports: per-source ready; at most one bit high.
- `m_axis_tdata`  out  Width: byte to FIFO.
- `m_axis_tvalid`  out  1: output valid.
- `m_axis_tready`  in  1: FIFO not full.
- `grant_id`  out  clog2(Ports): index of current or last grantee.
- `busy`  out  1: high while a grant is held (state ≠ IDLE).

## Operation

- FSM states are IDLE, HDR and XFER. HDR exists only when `ARB_ID_HEADER_EN` is defined.
- **IDLE**
  - `m_axis_tvalid`=0, all `s_axis_tready`=0, `m_axis_tdata`=0.
  - If any `s_axis_tvalid` is high, select the first requester scanning upward from `rr_ptr` and wrapping modulo `Ports`.
  - Register the selection into `grant_id`, clear the beat counter and idle counter, then go to HDR or XFER.
- **XFER**
  - `m_axis_tdata` = lane `grant_id`.
  - `m_axis_tvalid` = `s_axis_tvalid[grant_id]`.
  - `s_axis_tready[grant_id]` = `m_axis_tready`; all other ready bits are 0.
  - These paths are combinational.
  - A handshake is `m_axis_tvalid && m_axis_tready`. Each handshake increments the beat counter.
- **Release** (XFER → IDLE, `rr_ptr` ← `grant_id`+1 mod `Ports`) on any one of:
  - a handshake with `s_axis_tlast[grant_id]`=1;
  - a handshake that brings the beat count to `Max_burst`;
  - the idle counter reaching `Idle_limit`.
- **Idle counter**
  - Increments on each XFER cycle with `s_axis_tvalid[grant_id]`=0.
  - Clears on any cycle where that valid is high.
- A source cut off by `Max_burst` or the idle timeout keeps its remaining bytes. It re-competes through normal round-robin; no packet state is retained.
- Counter widths: beat counter is clog2(`Max_burst`+1) bits; idle counter is clog2(`Idle_limit`+1) bits. Neither counter wraps; release occurs at the limit.

## Timing

- Reset values:
  - state IDLE, `rr_ptr`=0, `grant_id`=0, `busy`=0;
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0;
  - both counters 0.
- Reset asserted mid-packet aborts the grant immediately. The partial packet is not completed or marked.
- Arbitration costs one bubble cycle: a request seen in IDLE at edge N makes the first output beat possible in the cycle after edge N (XFER), or after HDR when the header is enabled.
- Every release passes through one IDLE cycle. A 1-beat packet therefore occupies at least 2 cycles, or 3 with the header.
- Requests arriving while a grant is held are ignored until IDLE.
- `tvalid`/`tlast` changes on non-granted lanes have no effect.
- Backpressure: `m_axis_tready`=0 holds the beat. Data and valid remain those of the grantee, and the idle counter does not advance while the grantee's valid is high.
- Simultaneous `tlast` and `Max_burst` on the same beat: a single release; `rr_ptr` advances once.

## Configuration

- Macro: `ARB_ID_HEADER_EN`.
- **Defined:** after IDLE the FSM enters HDR.
  - HDR drives `m_axis_tvalid`=1 and `m_axis_tdata` = 8'hA0 + `grant_id` (`Width`=8 required); all `s_axis_tready`=0.
  - HDR moves to XFER on `m_axis_tready`=1.
  - The header is not counted toward `Max_burst`, and the idle counter is held at 0 during HDR.
- **Undefined:** HDR state and logic are absent, and IDLE goes directly to XFER.

## Test plan

- **Single source:** source 2 sends 3 bytes 0x11,0x22,0x33 (`tlast` on 0x33) with `m_axis_tready`=1.
  - Expected: bytes out in order on consecutive cycles after a 1-cycle bubble; `grant_id`=2; `busy` falls after the `tlast` handshake; `rr_ptr`=3.
- **Round robin:** all 4 sources continuously valid with 1-byte packets.
  - Expected: grant order 0,1,2,3,0; no source granted twice before all others.
- **Burst limit:** `Max_burst`=16, source 0 sends a 20-byte packet while source 1 is valid.
  - Expected: 16 bytes from source 0, then source 1's packet, then source 0's bytes 17–20.
- **Idle timeout:** granted source 1 drops `tvalid` after 2 beats, no `tlast`.
  - Expected: release after exactly 8 idle cycles; source 3 (pending) is granted next.
- **Backpressure and reset:** hold `m_axis_tready`=0 for 5 cycles mid-packet, then assert `rst` for 1 cycle.
  - Expected: data stable and the idle counter not advancing during the stall; after `rst`, all outputs are at reset values and `grant_id`=0.
- **Header (`ARB_ID_HEADER_EN`):** source 3 sends 0x55 with `tlast`.
  - Expected: output 0xA3 then 0x55; `Max_burst`=16 still allows 16 data bytes after the header.
